// File: rtl/bridge_tx_sched_pkg.sv
// Shared constants for the two-requester tx scheduler: default bus width,
// watchdog limit and FSM state encodings.
package bridge_tx_sched_pkg;

    localparam int DATA_MSB_DEF    = 31;
    localparam int TIMEOUT_CYC_DEF = 255;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // Bits needed to hold 0..limit; never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 2) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/bridge_rr_arb.sv
// Two-way round-robin winner select; purely combinational.
module bridge_rr_arb (
    input  logic req0,
    input  logic req1,
    input  logic last,
    output logic winner
);

    // On a tie the requester that was not served last wins; a lone request always wins.
    always_comb begin
        // NOTE: default assignment first so every path drives winner and no latch is inferred.
        winner = 1'b0;
        if (req0 && req1) begin
            winner = ~last;
        end else if (req1) begin
            winner = 1'b1;
        end
    end

endmodule

// File: rtl/bridge_tx_sched.sv
// Schedules two level-request payload sources onto a single tx port and
// tracks each transfer through to the tx sent confirmation.
module bridge_tx_sched
    import bridge_tx_sched_pkg::*;
#(
    parameter int DATA_MSB    = DATA_MSB_DEF,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_MSB:0] data0,
    output logic              gnt0,
    output logic              done0,
    input  logic              req1,
    input  logic [DATA_MSB:0] data1,
    output logic              gnt1,
    output logic              done1,
    output logic [DATA_MSB:0] sdata,
    output logic              vi,
    input  logic              snt,
    output logic              busy,
    output logic              timeout
);

    localparam int               CNT_W   = cnt_width(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

    logic [1:0]       state;
    logic             owner;
    logic             last;
    logic             winner;
    logic [CNT_W-1:0] wd_cnt;

    bridge_rr_arb u_arb (
        .req0   (req0),
        .req1   (req1),
        .last   (last),
        .winner (winner)
    );

    assign busy = (state != ST_IDLE);

    // Pulse outputs default low each cycle and are raised only by the transition that owns them.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            sdata   <= '0;
            vi      <= 1'b0;
            gnt0    <= 1'b0;
            gnt1    <= 1'b0;
            done0   <= 1'b0;
            done1   <= 1'b0;
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
            vi    <= 1'b0;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (req0 || req1) begin
                        state <= ST_ISSUE;
                        owner <= winner;
                        sdata <= winner ? data1 : data0;
                        vi    <= 1'b1;
                        gnt0  <= ~winner;
                        gnt1  <= winner;
                    end
                end
                ST_ISSUE: begin
                    state  <= ST_WAIT;
                    wd_cnt <= '0;
                end
                ST_WAIT: begin
                    // Watchdog only flags a stuck transfer; the FSM keeps waiting for snt.
                    if (wd_cnt != CNT_MAX) begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                    if (wd_cnt == CNT_MAX - 1'b1) begin
                        timeout <= 1'b1;
                    end
                    if (snt) begin
                        state <= ST_DONE;
                        last  <= owner;
                        done0 <= ~owner;
                        done1 <= owner;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
